uart_core_v2: RTL and testbench

Parametrised second-generation UART core: a shared baud tick generator, a TX engine and an RX engine, each decoupled from the host by a FIFO. It adds runtime parity and stop-bit selection, sticky error flags, and first-word-fall-through buffering. It replaces the single-byte `uart` top as the block instantiated by bus-side register wrappers.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_fifo.sv | 37 +++
 rtl/uart_core_v2.sv | 189 ++++++++++++++++++
 tb/tb_uart_core_v2.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and parity-mode encodings for uart_core_v2
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: first-word-fall-through FIFO with extra-MSB full/empty detection
module uart_fifo #(
  parameter int D_W     = 8,
  parameter int FIFO_AW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D_W-1:0] wdata,
  input  logic           wr,
  input  logic           rd,
  output logic [D_W-1:0] rdata,
  output logic           full,
  output logic           empty
);
  logic [D_W-1:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0] wp, rp;
  logic do_wr, do_rd;
  assign empty = wp == rp;
  assign full  = (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign rdata = empty ? '0 : mem[rp[FIFO_AW-1:0]];
  // pointer update; a pop frees the slot a same-cycle push into a full FIFO lands in
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
    end
  end
  // storage write
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[FIFO_AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/uart_core_v2.sv
// uart_core_v2: UART with baud tick generator, TX/RX FSMs and FIFOs; UART_PARITY_EN enables parity
module uart_core_v2 #(
  parameter int D_W     = 8,
  parameter int B_TICK  = 16,
  parameter int FIFO_AW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [15:0]    dvsr,
  input  logic [1:0]     parity_mode,
  input  logic           stop2,
  input  logic           rxd,
  output logic           txd,
  input  logic [D_W-1:0] tx_wdata,
  input  logic           tx_wr,
  output logic           tx_full,
  output logic           tx_busy,
  output logic [D_W-1:0] rx_rdata,
  input  logic           rx_rd,
  output logic           rx_empty,
  output logic           rx_parity_err,
  output logic           rx_frame_err,
  output logic           rx_overrun,
  input  logic           err_clr
);
  import uart_pkg::*;
  localparam int TW = $clog2(2 * B_TICK);
  localparam int RW = $clog2(B_TICK);
  localparam int BW = $clog2(D_W);
  localparam logic [TW-1:0] T_BIT   = TW'(B_TICK - 1);
  localparam logic [TW-1:0] T_STOP2 = TW'(2 * B_TICK - 1);
  localparam logic [RW-1:0] R_BIT   = RW'(B_TICK - 1);
  localparam logic [RW-1:0] R_HALF  = RW'(B_TICK / 2 - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(D_W - 1);
  logic [15:0] bcnt;
  logic tick, par_en, par_odd;
  logic tx_empty, tx_pop, rx_full, rx_push;
  logic [D_W-1:0] tx_head;
  state_t ts, ts_n, rs, rs_n;
  logic [TW-1:0] tt, tt_n;
  logic [RW-1:0] rt, rt_n;
  logic [BW-1:0] tb, tb_n, rb, rb_n;
  logic [D_W-1:0] tsh, tsh_n, rsh, rsh_n;
  logic tpen, tpen_n, tpar, tpar_n, ts2, ts2_n, txd_n, tdone;
  logic rpen, rpen_n, rodd, rodd_n, rbit;
  logic rs1, rs2, pe, pe_set, fe_set, ov_set;
  assign par_odd = parity_mode == PAR_ODD;
`ifdef UART_PARITY_EN
  assign par_en = parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
  assign rx_parity_err = pe;
`else
  logic unused_pe;
  assign par_en = 1'b0;
  assign rx_parity_err = 1'b0;
  assign unused_pe = pe;
`endif
  assign tick = bcnt == dvsr;
  // baud counter 0..dvsr, tick on the terminal count
  always_ff @(posedge clk) begin
    if (rst) bcnt <= '0;
    else bcnt <= tick ? '0 : bcnt + 16'd1;
  end
  uart_fifo #(.D_W(D_W), .FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .wdata(tx_wdata), .wr(tx_wr), .rd(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );
  uart_fifo #(.D_W(D_W), .FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .wdata(rsh), .wr(rx_push), .rd(rx_rd),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );
  assign tx_busy = ts != IDLE || !tx_empty;
  assign tdone = tick && tt == ((ts == STOP && ts2) ? T_STOP2 : T_BIT);
  // TX state and datapath registers; txd is registered so it lags the state by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ts <= IDLE; tt <= '0; tb <= '0; tsh <= '0;
      tpen <= 1'b0; tpar <= 1'b0; ts2 <= 1'b0; txd <= 1'b1;
    end else begin
      ts <= ts_n; tt <= tt_n; tb <= tb_n; tsh <= tsh_n;
      tpen <= tpen_n; tpar <= tpar_n; ts2 <= ts2_n; txd <= txd_n;
    end
  end
  // TX next state: frame options latched at pop, each bit held until its tick budget is spent
  always_comb begin
    ts_n = ts;
    tt_n = (ts == IDLE || tdone) ? '0 : (tick ? tt + 1'b1 : tt);
    tb_n = tb;
    tsh_n = tsh;
    tpen_n = tpen;
    tpar_n = tpar;
    ts2_n = ts2;
    tx_pop = 1'b0;
    txd_n = 1'b1;
    case (ts)
      IDLE: if (!tx_empty) begin
        tx_pop = 1'b1;
        ts_n = START;
        tsh_n = tx_head;
        tb_n = '0;
        tpen_n = par_en;
        tpar_n = ^tx_head ^ par_odd;
        ts2_n = stop2;
      end
      START: begin
        txd_n = 1'b0;
        if (tdone) ts_n = DATA;
      end
      DATA: begin
        txd_n = tsh[0];
        if (tdone) begin
          tsh_n = tsh >> 1;
          tb_n = tb + 1'b1;
          if (tb == B_LAST) ts_n = tpen ? PARITY : STOP;
        end
      end
      PARITY: begin
        txd_n = tpar;
        if (tdone) ts_n = STOP;
      end
      default: if (tdone) ts_n = IDLE;
    endcase
  end
  // rxd synchronizer, idles high
  always_ff @(posedge clk) begin
    if (rst) {rs2, rs1} <= 2'b11;
    else {rs2, rs1} <= {rs1, rxd};
  end
  assign rbit = tick && rt == R_BIT;
  // RX state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rs <= IDLE; rt <= '0; rb <= '0; rsh <= '0; rpen <= 1'b0; rodd <= 1'b0;
    end else begin
      rs <= rs_n; rt <= rt_n; rb <= rb_n; rsh <= rsh_n; rpen <= rpen_n; rodd <= rodd_n;
    end
  end
  // RX next state: mid-bit sampling, a high start sample is treated as a glitch
  always_comb begin
    rs_n = rs;
    rt_n = (rs == IDLE) ? '0 : (tick ? rt + 1'b1 : rt);
    rb_n = rb;
    rsh_n = rsh;
    rpen_n = rpen;
    rodd_n = rodd;
    rx_push = 1'b0;
    pe_set = 1'b0;
    fe_set = 1'b0;
    case (rs)
      IDLE: if (!rs2) begin
        rs_n = START;
        rpen_n = par_en;
        rodd_n = par_odd;
      end
      START: if (tick && rt == R_HALF) begin
        rt_n = '0;
        rb_n = '0;
        rs_n = rs2 ? IDLE : DATA;
      end
      DATA: if (rbit) begin
        rt_n = '0;
        rsh_n = {rs2, rsh[D_W-1:1]};
        rb_n = rb + 1'b1;
        if (rb == B_LAST) rs_n = rpen ? PARITY : STOP;
      end
      PARITY: if (rbit) begin
        rt_n = '0;
        pe_set = rs2 != (^rsh ^ rodd);
        rs_n = STOP;
      end
      default: if (rbit) begin
        rt_n = '0;
        rx_push = 1'b1;
        fe_set = !rs2;
        rs_n = IDLE;
      end
    endcase
  end
  assign ov_set = rx_push && rx_full && !rx_rd;
  // sticky error flags, a set wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pe <= 1'b0; rx_frame_err <= 1'b0; rx_overrun <= 1'b0;
    end else begin
      pe <= pe_set || (pe && !err_clr);
      rx_frame_err <= fe_set || (rx_frame_err && !err_clr);
      rx_overrun <= ov_set || (rx_overrun && !err_clr);
    end
  end
endmodule

// File: tb/tb_uart_core_v2.sv
// tb_uart_core_v2: directed self-checking bench for uart_core_v2 (dvsr=3, 64 clk per bit)
module tb_uart_core_v2;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] dvsr = 16'd3;
  logic [1:0] parity_mode = 2'b00;
  logic stop2 = 1'b0, rxd, txd, tx_wr = 1'b0, tx_full, tx_busy;
  logic [7:0] tx_wdata = 8'h00, rx_rdata;
  logic rx_rd = 1'b0, rx_empty, rx_parity_err, rx_frame_err, rx_overrun, err_clr = 1'b0;
  logic loop = 1'b0, rx_drv = 1'b1;
  int errors = 0, checks = 0;
  int n, nfall;
  logic prev;

  assign rxd = loop ? txd : rx_drv;
  always #5 clk = ~clk;

  uart_core_v2 dut (
    .clk(clk), .rst(rst), .dvsr(dvsr), .parity_mode(parity_mode), .stop2(stop2),
    .rxd(rxd), .txd(txd), .tx_wdata(tx_wdata), .tx_wr(tx_wr), .tx_full(tx_full),
    .tx_busy(tx_busy), .rx_rdata(rx_rdata), .rx_rd(rx_rd), .rx_empty(rx_empty),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_overrun(rx_overrun), .err_clr(err_clr)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_txd(input logic v, input int budget, output int cnt);
    cnt = 0;
    while (txd !== v && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic wait_rx(input string tag);
    int k = 0;
    while (rx_empty && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk1(tag, rx_empty, 1'b0);
  endtask

  task automatic pop();
    rx_rd = 1'b1;
    cyc(1);
    rx_rd = 1'b0;
  endtask

  task automatic clr();
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pbit, input logic pval, input logic sval);
    rx_drv = 1'b0;
    cyc(64);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      cyc(64);
    end
    if (pbit) begin
      rx_drv = pval;
      cyc(64);
    end
    rx_drv = sval;
    cyc(48);
    rx_drv = 1'b1;
    cyc(80);
  endtask

  initial begin
    cyc(3);
    chk1("rst_txd", txd, 1'b1);
    chk1("rst_tx_full", tx_full, 1'b0);
    chk1("rst_tx_busy", tx_busy, 1'b0);
    chk1("rst_rx_empty", rx_empty, 1'b1);
    chk8("rst_rx_rdata", rx_rdata, 8'h00);
    chk1("rst_frame_err", rx_frame_err, 1'b0);
    chk1("rst_overrun", rx_overrun, 1'b0);
    chk1("rst_parity_err", rx_parity_err, 1'b0);
    rst = 1'b0;
    cyc(5);

    loop = 1'b1;
    tx_wdata = 8'hA5;
    tx_wr = 1'b1;
    cyc(1);
    chk1("busy_after_wr", tx_busy, 1'b1);
    chk1("txd_idle_n", txd, 1'b1);
    tx_wdata = 8'h3C;
    cyc(1);
    tx_wr = 1'b0;
    chk1("txd_idle_n1", txd, 1'b1);
    cyc(1);
    chk1("txd_start_n2", txd, 1'b0);
    wait_txd(1'b1, 100, n);
    chk1("start_end", txd, 1'b1);
    wait_txd(1'b0, 100, n);
    chki("bit_period", n, 64);
    wait_rx("lb_rx1");
    chk8("lb_data1", rx_rdata, 8'hA5);
    pop();
    wait_rx("lb_rx2");
    chk8("lb_data2", rx_rdata, 8'h3C);
    pop();
    chk1("lb_empty", rx_empty, 1'b1);
    chk1("lb_frame_err", rx_frame_err, 1'b0);
    chk1("lb_parity_err", rx_parity_err, 1'b0);
    chk1("lb_overrun", rx_overrun, 1'b0);
    cyc(200);

`ifdef UART_PARITY_EN
    parity_mode = 2'b01;
    tx_wdata = 8'h07;
    tx_wr = 1'b1;
    cyc(1);
    tx_wr = 1'b0;
    wait_txd(1'b0, 100, n);
    wait_txd(1'b1, 100, n);
    cyc(480);
    chk1("par_tx_bit7", txd, 1'b0);
    cyc(64);
    chk1("par_tx_bit", txd, 1'b1);
    wait_rx("par_lb_rx");
    chk8("par_lb_data", rx_rdata, 8'h07);
    chk1("par_lb_noerr", rx_parity_err, 1'b0);
    pop();
    cyc(200);
    loop = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1);
    chk1("par_err_set", rx_parity_err, 1'b1);
    chk8("par_err_data", rx_rdata, 8'h07);
    clr();
    chk1("par_err_clr", rx_parity_err, 1'b0);
    pop();
    parity_mode = 2'b00;
`endif

    loop = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    chk1("fe_pushed", rx_empty, 1'b0);
    chk8("fe_data", rx_rdata, 8'h5A);
    chk1("fe_set", rx_frame_err, 1'b1);
    chk1("fe_no_parity", rx_parity_err, 1'b0);
    clr();
    chk1("fe_clr", rx_frame_err, 1'b0);
    pop();
    chk1("fe_empty", rx_empty, 1'b1);

    rx_drv = 1'b0;
    cyc(16);
    rx_drv = 1'b1;
    cyc(700);
    chk1("glitch_no_push", rx_empty, 1'b1);
    chk1("glitch_no_fe", rx_frame_err, 1'b0);

    for (int i = 0; i < 17; i++) begin
      send_frame(8'(16 + i), 1'b0, 1'b0, 1'b1);
      if (i == 15) chk1("ovr_not_yet", rx_overrun, 1'b0);
    end
    chk1("ovr_set", rx_overrun, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk8("ovr_data", rx_rdata, 8'(16 + i));
      pop();
    end
    chk1("ovr_drained", rx_empty, 1'b1);
    clr();
    chk1("ovr_clr", rx_overrun, 1'b0);

    stop2 = 1'b1;
    tx_wdata = 8'h00;
    tx_wr = 1'b1;
    for (int i = 0; i < 18; i++) begin
      cyc(1);
      if (i == 15) chk1("tx_not_full_16w", tx_full, 1'b0);
      if (i == 16) chk1("tx_full_17w", tx_full, 1'b1);
      if (i == 17) chk1("tx_full_18w", tx_full, 1'b1);
    end
    tx_wr = 1'b0;
    stop2 = 1'b0;
    wait_txd(1'b1, 1000, n);
    wait_txd(1'b0, 1000, n);
    chki("stop2_gap", n, 129);
    nfall = 2;
    prev = txd;
    n = 0;
    while (tx_busy && n < 15000) begin
      cyc(1);
      n++;
      if (prev && !txd) nfall++;
      prev = txd;
    end
    chk1("tx_drained", tx_busy, 1'b0);
    chki("tx_frame_count", nfall, 17);

    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    tx_wdata = 8'h00;
    tx_wr = 1'b1;
    cyc(1);
    tx_wr = 1'b0;
    cyc(200);
    chk1("pre_rst_txd", txd, 1'b0);
    chk1("pre_rst_fe", rx_frame_err, 1'b1);
    rst = 1'b1;
    cyc(1);
    chk1("mid_rst_txd", txd, 1'b1);
    chk1("mid_rst_busy", tx_busy, 1'b0);
    chk1("mid_rst_rx_empty", rx_empty, 1'b1);
    chk1("mid_rst_fe", rx_frame_err, 1'b0);
    chk8("mid_rst_rdata", rx_rdata, 8'h00);
    rst = 1'b0;
    cyc(100);
    chk1("post_rst_txd", txd, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
